// File: rtl/gpu_pkg.sv
// gpu_pkg: shared opcodes, instruction field positions and sequencer state encoding
package gpu_pkg;
    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_SET_COLOR  = 8'h01;
    localparam logic [7:0] OP_SET_CURSOR = 8'h02;
    localparam logic [7:0] OP_PIXEL      = 8'h03;
    localparam logic [7:0] OP_HLINE      = 8'h04;
    localparam logic [7:0] OP_CLEAR      = 8'h05;
    localparam int OPC_LSB  = 0;
    localparam int ARG2_LSB = 8;
    localparam int ARG1_LSB = 16;
    localparam int ARG0_LSB = 24;
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WRITE, S_RELEASE, S_DRAIN} state_t;
endpackage

// File: rtl/gpu_cursor.sv
// gpu_cursor: x/y drawing cursor with load, raster-order advance with wrap, and linear address
module gpu_cursor #(
    parameter int H_RES  = 80,
    parameter int V_RES  = 60,
    parameter int ADDR_W = 13
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [7:0]        i_x,
    input  logic [7:0]        i_y,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr
);
    logic [7:0] x, y;
    // load wins over advance; advance steps right, then down, wrapping at the last pixel
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            x <= 8'd0;
            y <= 8'd0;
        end else if (i_load) begin
            x <= i_x;
            y <= i_y;
        end else if (i_advance) begin
            x <= (x == 8'(H_RES-1)) ? 8'd0 : x + 8'd1;
            y <= (x != 8'(H_RES-1)) ? y : (y == 8'(V_RES-1)) ? 8'd0 : y + 8'd1;
        end
    end
    assign o_addr = ADDR_W'(32'(y) * 32'(H_RES) + 32'(x));
endmodule

// File: rtl/gpu_cmd_sequencer.sv
// gpu_cmd_sequencer: executes buffered draw instructions as framebuffer write bursts
module gpu_cmd_sequencer
    import gpu_pkg::*;
#(
    parameter int H_RES   = 80,
    parameter int V_RES   = 60,
    parameter int ADDR_W  = 13,
    parameter int COLOR_W = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [31:0]        i_instruction,
    input  logic               i_ready,
    output logic               o_buf_reset,
    output logic [ADDR_W-1:0]  o_fb_addr,
    output logic [COLOR_W-1:0] o_fb_data,
    output logic               o_fb_valid,
    input  logic               i_fb_ready,
    output logic               o_busy,
    output logic               o_error
);
    state_t             state;
    logic [23:0]        instr;
    logic [COLOR_W-1:0] color;
    logic [15:0]        count;
    logic [7:0]         op, arg1, arg2;
    logic               load, hs, unused_arg0;

    function automatic logic bad_instr(input logic [23:0] w);
        return (w[OPC_LSB +: 8] > OP_CLEAR) ||
               ((w[OPC_LSB +: 8] == OP_SET_CURSOR) &&
                (({1'b0, w[ARG1_LSB +: 8]} >= 9'(H_RES)) || ({1'b0, w[ARG2_LSB +: 8]} >= 9'(V_RES))));
    endfunction

    assign unused_arg0 = ^i_instruction[ARG0_LSB +: 8];
    assign op   = instr[OPC_LSB +: 8];
    assign arg1 = instr[ARG1_LSB +: 8];
    assign arg2 = instr[ARG2_LSB +: 8];
    assign hs   = o_fb_valid && i_fb_ready;
    assign load = (state == S_DECODE) && ((op == OP_CLEAR) || ((op == OP_SET_CURSOR) && !bad_instr(instr)));
    assign o_fb_data = color;

    gpu_cursor #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_cursor (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (load),
        .i_x       (op == OP_CLEAR ? 8'd0 : arg1),
        .i_y       (op == OP_CLEAR ? 8'd0 : arg2),
        .i_advance (hs),
        .o_addr    (o_fb_addr)
    );

    // instruction FSM; error is flagged on latch so it is visible during DECODE
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            instr       <= 24'd0;
            color       <= '0;
            count       <= 16'd0;
            o_buf_reset <= 1'b0;
            o_fb_valid  <= 1'b0;
            o_busy      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_buf_reset <= 1'b0;
            o_error     <= 1'b0;
            case (state)
                S_IDLE: if (i_ready) begin
                    instr   <= i_instruction[23:0];
                    o_error <= bad_instr(i_instruction[23:0]);
                    o_busy  <= 1'b1;
                    state   <= S_DECODE;
                end
                S_DECODE: begin
                    if (op == OP_SET_COLOR) color <= arg2[COLOR_W-1:0];
                    count <= (op == OP_CLEAR) ? 16'(H_RES*V_RES) : (op == OP_HLINE) ? {8'd0, arg2} : 16'd1;
                    if ((op == OP_PIXEL) || (op == OP_CLEAR) || ((op == OP_HLINE) && (arg2 != 8'd0))) begin
                        o_fb_valid <= 1'b1;
                        state      <= S_WRITE;
                    end else begin
                        o_buf_reset <= 1'b1;
                        state       <= S_RELEASE;
                    end
                end
                S_WRITE: if (hs) begin
                    count <= count - 16'd1;
                    if (count == 16'd1) begin
                        o_fb_valid  <= 1'b0;
                        o_buf_reset <= 1'b1;
                        state       <= S_RELEASE;
                    end
                end
                S_RELEASE: state <= S_DRAIN;
                S_DRAIN: if (!i_ready) begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
